// File: rtl/dco_trim_controller_if.sv
// Signal bundle between the DCO trim controller and its surroundings.
// The master drives the controls and the reference; the slave is the controller.
interface dco_trim_controller_if #(
  parameter int unsigned TRIM_W = 26,
  parameter int unsigned DIV_W  = 5,
  parameter int unsigned CNT_W  = 7
);
  logic              ENABLE;
  logic              REF;
  logic [DIV_W-1:0]  DIV;
  logic              EXT_SEL;
  logic [TRIM_W-1:0] EXT_TRIM;
  logic [TRIM_W-1:0] TRIM;
  logic              LOCKED;
  logic [CNT_W-1:0]  PERIOD;

  modport master (
    output ENABLE, REF, DIV, EXT_SEL, EXT_TRIM,
    input  TRIM, LOCKED, PERIOD
  );

  modport slave (
    input  ENABLE, REF, DIV, EXT_SEL, EXT_TRIM,
    output TRIM, LOCKED, PERIOD
  );
endinterface

// File: rtl/dco_trim_controller.sv
// Frequency-lock loop for the ring DCO: counts DCO cycles per REF period and
// walks a thermometer trim word one stage at a time toward the DIV target.
module dco_trim_controller #(
  parameter int unsigned       TRIM_W     = 26,
  parameter int unsigned       DIV_W      = 5,
  parameter int unsigned       CNT_W      = 7,
  parameter int unsigned       TOL        = 1,
  parameter int unsigned       LOCK_N     = 4,
  parameter logic [TRIM_W-1:0] TRIM_RESET = TRIM_W'(26'h0001FFF)
) (
  input  logic                  CLK,
  input  logic                  RESETB,
  dco_trim_controller_if.slave  bus
);

  localparam int unsigned CMP_W  = CNT_W + 1;
  localparam int unsigned LOCK_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [LOCK_W-1:0] LOCK_SAT = LOCK_W'(LOCK_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_s1, r_s2, r_s3;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_period, w_period_nxt;
  logic [TRIM_W-1:0] r_trim, w_trim_nxt;
  logic [LOCK_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic              r_locked, w_locked_nxt;

  logic              w_ref_rise;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [LOCK_W-1:0] w_lock_inc;
  logic [CMP_W-1:0]  w_m;
  logic [CMP_W-1:0]  w_div;
  logic              w_too_fast;
  logic              w_too_slow;
  logic [TRIM_W-1:0] w_trim_up;
  logic [TRIM_W-1:0] w_trim_dn;

  // REF crossing into the DCO domain and rising-edge detect
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.REF;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_ref_rise = r_s2 & ~r_s3;

  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_lock_inc = (r_lock_cnt == LOCK_SAT) ? r_lock_cnt : r_lock_cnt + LOCK_W'(1);

  // One extra bit keeps DIV+TOL and m+TOL from wrapping
  assign w_m        = CMP_W'(r_cnt);
  assign w_div      = CMP_W'(bus.DIV);
  assign w_too_fast = (r_cnt == CNT_MAX) || (w_m > (w_div + CMP_W'(TOL)));
  assign w_too_slow = (w_m + CMP_W'(TOL)) < w_div;

  assign w_trim_up  = {r_trim[TRIM_W-2:0], 1'b1};
  assign w_trim_dn  = {1'b0, r_trim[TRIM_W-1:1]};

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_period_nxt   = r_period;
    w_trim_nxt     = r_trim;
    w_lock_cnt_nxt = r_lock_cnt;
    w_locked_nxt   = r_locked;

    if (!bus.ENABLE || bus.EXT_SEL) begin
      w_state_nxt    = ST_IDLE;
      w_cnt_nxt      = '0;
      w_lock_cnt_nxt = '0;
      w_locked_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_FIRST;
        end
        // The partial period before the first REF edge is thrown away
        ST_FIRST: begin
          if (w_ref_rise) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_TRACK;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        ST_TRACK: begin
          if (w_ref_rise) begin
            w_cnt_nxt    = CNT_W'(1);
            w_period_nxt = r_cnt;
            if (w_too_fast) begin
              w_trim_nxt     = w_trim_up;
              w_lock_cnt_nxt = '0;
              w_locked_nxt   = 1'b0;
            end else if (w_too_slow) begin
              w_trim_nxt     = w_trim_dn;
              w_lock_cnt_nxt = '0;
              w_locked_nxt   = 1'b0;
            end else begin
              w_lock_cnt_nxt = w_lock_inc;
              w_locked_nxt   = (w_lock_inc == LOCK_SAT);
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_cnt      <= '0;
      r_period   <= '0;
      r_trim     <= TRIM_RESET;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_period   <= w_period_nxt;
      r_trim     <= w_trim_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  // Override is a plain mux so the internal trim stays frozen underneath it
  assign bus.TRIM   = bus.EXT_SEL ? bus.EXT_TRIM : r_trim;
  assign bus.LOCKED = r_locked;
  assign bus.PERIOD = r_period;

endmodule

// File: tb/tb_dco_trim_controller.sv
// Self-checking bench for dco_trim_controller: directed vector table, timed
// corner sequences, and randomized REF periods against a stage-count model.
module tb_dco_trim_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dco_trim_controller_if #(.TRIM_W(26), .DIV_W(5), .CNT_W(7)) bus ();

  dco_trim_controller u_dut (
    .CLK    (clk),
    .RESETB (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  typedef struct {
    int unsigned period;
    logic [25:0] trim;
    logic        locked;
    logic [6:0]  per;
  } vec_t;

  vec_t vecs[26];

  function automatic logic [25:0] therm(input int n);
    return 26'((64'(1) << n) - 64'(1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // One REF period of p CLK cycles, rising edge at the current negedge
  task automatic run_period(input int unsigned p);
    bus.REF = 1'b1;
    for (int i = 0; i < int'(p); i++) begin
      @(negedge clk);
      if (i + 1 == int'(p / 2)) bus.REF = 1'b0;
    end
  endtask

  // Same as run_period, sampling outputs just after edges k+1 and k+2
  task automatic rise_timed(input int unsigned p,
                            output logic [25:0] tr_b, output logic lk_b,
                            output logic [25:0] tr_a, output logic lk_a);
    tr_b = '0; lk_b = 1'b0; tr_a = '0; lk_a = 1'b0;
    bus.REF = 1'b1;
    for (int i = 0; i < int'(p); i++) begin
      @(negedge clk);
      if (i == 1) begin tr_b = bus.TRIM; lk_b = bus.LOCKED; end
      if (i == 2) begin tr_a = bus.TRIM; lk_a = bus.LOCKED; end
      if (i + 1 == int'(p / 2)) bus.REF = 1'b0;
    end
  endtask

  task automatic do_reset();
    bus.ENABLE   = 1'b0;
    bus.EXT_SEL  = 1'b0;
    bus.EXT_TRIM = '0;
    bus.REF      = 1'b0;
    bus.DIV      = 5'd8;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trim",   32'(bus.TRIM),   32'h0001FFF);
    chk("rst_locked", 32'(bus.LOCKED), 32'd0);
    chk("rst_period", 32'(bus.PERIOD), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [25:0] tr_b, tr_a, ext;
    logic        lk_b, lk_a;
    int          ones, lock, per, div, prev_p, p, m, lo;
    bit          need_first;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;

    // Vector table: period to drive, outputs expected once its leading edge is processed
    vecs[0] = '{12, 26'h0001FFF, 1'b0, 7'd0};
    vecs[1] = '{12, 26'h0003FFF, 1'b0, 7'd12};
    vecs[2] = '{8,  26'h0007FFF, 1'b0, 7'd12};
    vecs[3] = '{9,  26'h0007FFF, 1'b0, 7'd8};
    vecs[4] = '{7,  26'h0007FFF, 1'b0, 7'd9};
    vecs[5] = '{8,  26'h0007FFF, 1'b0, 7'd7};
    vecs[6] = '{11, 26'h0007FFF, 1'b1, 7'd8};
    vecs[7] = '{5,  26'h000FFFF, 1'b0, 7'd11};
    for (int j = 0; j < 18; j++)
      vecs[8 + j] = '{5, therm((15 > j) ? 15 - j : 0), 1'b0, 7'd5};

    do_reset();
    bus.DIV    = 5'd8;
    bus.ENABLE = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      run_period(vecs[i].period);
      chk($sformatf("vec%0d_trim", i),   32'(bus.TRIM),   32'(vecs[i].trim));
      chk($sformatf("vec%0d_locked", i), 32'(bus.LOCKED), 32'(vecs[i].locked));
      chk($sformatf("vec%0d_period", i), 32'(bus.PERIOD), 32'(vecs[i].per));
    end

    // Lock rises exactly at k+2 of the 4th in-window edge; an 11-cycle period breaks it
    bus.ENABLE = 1'b0;
    repeat (2) @(negedge clk);
    bus.ENABLE = 1'b1;
    repeat (4) @(negedge clk);
    repeat (4) run_period(8);
    rise_timed(11, tr_b, lk_b, tr_a, lk_a);
    chk("lock_before_k2", 32'(lk_b), 32'd0);
    chk("lock_at_k2",     32'(lk_a), 32'd1);
    chk("lock_trim_hold", 32'(tr_a), 32'd0);
    rise_timed(8, tr_b, lk_b, tr_a, lk_a);
    chk("unlock_before_lk", 32'(lk_b), 32'd1);
    chk("unlock_before_tr", 32'(tr_b), 32'd0);
    chk("unlock_at_k2_lk",  32'(lk_a), 32'd0);
    chk("unlock_at_k2_tr",  32'(tr_a), 32'd1);
    repeat (4) run_period(8);
    chk("relock", 32'(bus.LOCKED), 32'd1);

    // Asynchronous reset in the middle of a measurement
    bus.REF = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_trim",   32'(bus.TRIM),   32'h0001FFF);
    chk("midrst_locked", 32'(bus.LOCKED), 32'd0);
    chk("midrst_period", 32'(bus.PERIOD), 32'd0);
    bus.REF = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Override: immediate mux, internal trim frozen, first edge after release discarded
    bus.DIV    = 5'd8;
    bus.ENABLE = 1'b1;
    repeat (4) @(negedge clk);
    run_period(12);
    run_period(12);
    chk("pre_ovr_trim", 32'(bus.TRIM), 32'h0003FFF);
    bus.EXT_TRIM = 26'h3FFFFFF;
    bus.EXT_SEL  = 1'b1;
    #1;
    chk("ovr_trim_now", 32'(bus.TRIM), 32'h3FFFFFF);
    @(negedge clk);
    chk("ovr_locked", 32'(bus.LOCKED), 32'd0);
    ext = 26'($urandom);
    bus.EXT_TRIM = ext;
    #1;
    chk("ovr_trim_rand", 32'(bus.TRIM), 32'(ext));
    repeat (3) run_period(5);
    bus.EXT_SEL = 1'b0;
    #1;
    chk("ovr_release_trim", 32'(bus.TRIM), 32'h0003FFF);
    repeat (30) @(negedge clk);
    run_period(8);
    chk("ovr_discard_trim",   32'(bus.TRIM),   32'h0003FFF);
    chk("ovr_discard_period", 32'(bus.PERIOD), 32'd12);
    run_period(8);
    chk("ovr_track_trim",   32'(bus.TRIM),   32'h0003FFF);
    chk("ovr_track_period", 32'(bus.PERIOD), 32'd8);

    // REF lost: counter saturates and the next edge steps up
    repeat (200) @(negedge clk);
    run_period(8);
    chk("sat_period", 32'(bus.PERIOD), 32'd127);
    chk("sat_trim",   32'(bus.TRIM),   32'h0007FFF);

    // Randomized periods against a stage-count model
    do_reset();
    ones = 13; lock = 0; per = 0;
    for (int r = 0; r < 6; r++) begin
      bus.ENABLE = 1'b0;
      repeat (3) @(negedge clk);
      div = int'($urandom_range(4, 24));
      bus.DIV = 5'(div);
      bus.ENABLE = 1'b1;
      repeat (5) @(negedge clk);
      need_first = 1'b1;
      lock = 0;
      prev_p = 0;
      for (int n = 0; n < 25; n++) begin
        lo = (div >= 6) ? div - 3 : 3;
        if ($urandom_range(0, 7) == 0) p = int'($urandom_range(3, 60));
        else p = int'($urandom_range(lo, div + 4));
        if (need_first) begin
          need_first = 1'b0;
        end else begin
          m = (prev_p > 127) ? 127 : prev_p;
          per = m;
          if (m == 127 || m > div + 1) begin
            if (ones < 26) ones++;
            lock = 0;
          end else if (m + 1 < div) begin
            if (ones > 0) ones--;
            lock = 0;
          end else if (lock < 4) begin
            lock++;
          end
        end
        run_period(p);
        prev_p = p;
        chk($sformatf("rnd%0d_%0d_trim", r, n),   32'(bus.TRIM),   32'(therm(ones)));
        chk($sformatf("rnd%0d_%0d_locked", r, n), 32'(bus.LOCKED), (lock == 4) ? 32'd1 : 32'd0);
        chk($sformatf("rnd%0d_%0d_period", r, n), 32'(bus.PERIOD), 32'(per));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dco_trim_controller.md
Name: dco_trim_controller

Overview:
- Frequency-lock controller for the digital PLL ring oscillator, built from einvp/einvn trim stages.
- Clocked by the DCO output itself. It measures DCO cycles per reference period and steps a thermometer-coded trim word that drives the oscillator's tristate-inverter delay stages.
- More trim ones give more delay and a lower DCO frequency.
- Provides an external trim override and a lock indication.

Parameters:
- TRIM_W, 26, trim word width (number of trimmable delay stages).
- DIV_W, 5, width of the DIV target input.
- CNT_W, 7, period counter width; must be at least DIV_W+1.
- TOL, 1, hysteresis in DCO cycles; no step while |measured-DIV| <= TOL.
- LOCK_N, 4, number of consecutive in-window measurements before LOCKED asserts.
- TRIM_RESET, 26'h0001FFF, internal trim value after reset (13 ones).

Ports:
- CLK  input  1  DCO output clock; all state on its rising edge.
- RESETB  input  1  asynchronous active-low reset.
- ENABLE  input  1  controller enable; level sensitive.
- REF  input  1  reference clock, asynchronous to CLK.
- DIV  input  DIV_W  target DCO cycles per REF period; static while ENABLE=1.
- EXT_SEL  input  1  1: TRIM driven from EXT_TRIM.
- EXT_TRIM  input  TRIM_W  external trim value.
- TRIM  output  TRIM_W  trim to the oscillator.
- LOCKED  output  1  frequency lock flag.
- PERIOD  output  CNT_W  last measured period, for debug.

Behaviour:
- Reset (RESETB=0, asynchronous):
  - sync flops, counter, PERIOD and lock counter cleared to 0.
  - internal trim = TRIM_RESET; LOCKED=0; state IDLE.
- REF synchroniser: three flops s1->s2->s3; edge pulse ref_rise = s2 & ~s3.
  - If CLK edge k is the first to sample REF=1 into s1, ref_rise is high in the cycle after edge k+1.
  - Registered actions on that pulse occur at edge k+2.
- Period counter:
  - Increments every CLK while state is FIRST or TRACK.
  - Saturates at 2^CNT_W-1.
  - On ref_rise it is reloaded to 1 and its prior value is captured into PERIOD (measured value).
- FSM states: IDLE, FIRST, TRACK.
  - IDLE: entered on reset, or when ENABLE=0 or EXT_SEL=1 (checked every cycle, highest priority). Counter=0, LOCKED=0, lock counter=0, internal trim held. Leaves to FIRST when ENABLE=1 and EXT_SEL=0.
  - FIRST: on ref_rise, reload counter and go to TRACK. PERIOD is not updated and no trim step occurs, because this partial period is discarded.
  - TRACK: on each ref_rise, compare the measured value m with DIV, using CNT_W+1-bit unsigned arithmetic with no overflow:
    - m > DIV+TOL (DCO too fast): trim <= {trim[TRIM_W-2:0],1'b1}.
    - m + TOL < DIV (too slow): trim <= {1'b0,trim[TRIM_W-1:1]}.
    - otherwise: trim held, lock counter increments, saturating at LOCK_N.
    - Any step request clears the lock counter and LOCKED in the same edge, even if the trim is saturated (all-ones with up, all-zeros with down). The trim value is unchanged in the saturated case.
- Lock flag: LOCKED <= 1 on the edge where the lock counter reaches LOCK_N; it stays 1 while the counter remains saturated.
- Saturated counter: m = 2^CNT_W-1 counts as too fast (REF lost or very slow).
- TRIM output: combinational mux, EXT_SEL ? EXT_TRIM : internal trim.
  - The internal trim is frozen during override.
  - Returning EXT_SEL to 0 restarts at FIRST with the pre-override internal trim.
- The trim word is always thermometer-shaped (contiguous ones from LSB) given a thermometer TRIM_RESET. There is no single-cycle multi-bit jump.
- Reset mid-measurement aborts it. No TRIM glitch other than the asynchronous load of TRIM_RESET.

Test Plan:
- Reset: RESETB=0 with CLK running -> TRIM=26'h0001FFF, LOCKED=0, PERIOD=0. Release, ENABLE=1, then the first REF edge -> no trim change, PERIOD still 0.
- Too fast: DIV=8, TOL=1, REF period = 12 CLK -> from the second REF edge onward, TRIM gains one LSB-side one per REF edge (13 -> 14 -> 15 ones), PERIOD=12, LOCKED=0.
- Too slow: DIV=8, REF period = 5 CLK -> TRIM loses one MSB-side one per edge; after 13 steps TRIM=0. A further edge keeps TRIM=0 and LOCKED=0.
- Lock: DIV=8, REF period alternating 8/9/7 CLK -> TRIM constant. LOCKED rises at edge k+2 of the 4th in-window REF edge. A single 11-cycle period then deasserts LOCKED and adds one trim bit.
- Override: EXT_SEL=1, EXT_TRIM=26'h3FFFFFF -> TRIM=26'h3FFFFFF in the same cycle, LOCKED=0. EXT_SEL=0 -> TRIM returns to the previous internal value and the first REF edge after that is discarded.
- Reset mid-operation: assert RESETB=0 while the counter is at 5 and LOCKED=1 -> immediately TRIM=TRIM_RESET, LOCKED=0. Stopping REF while enabled -> the counter saturates at 127 and the next edge causes an up-step.
